// File: rtl/rgb_timing_pattern_gen.sv
// Progressive video timing generator (VS/HS/DE) with a selectable 8-bit-per-channel RGB test pattern.
// Every output comes from one shared register stage that is fed by the counter values.
module rgb_timing_pattern_gen #(
   parameter int unsigned H_ACTIVE = 1280,
   parameter int unsigned H_FP     = 110,
   parameter int unsigned H_SYNC   = 40,
   parameter int unsigned H_BP     = 220,
   parameter int unsigned V_ACTIVE = 720,
   parameter int unsigned V_FP     = 5,
   parameter int unsigned V_SYNC   = 5,
   parameter int unsigned V_BP     = 20,
   parameter bit          HS_POL   = 1'b1,
   parameter bit          VS_POL   = 1'b1
) (
   input  logic       I_rgb_clk,
   input  logic       I_rst,
   input  logic [1:0] I_mode,
   output logic       O_rgb_vs,
   output logic       O_rgb_hs,
   output logic       O_rgb_de,
   output logic [7:0] O_rgb_r,
   output logic [7:0] O_rgb_g,
   output logic [7:0] O_rgb_b,
   output logic       O_frame_start
);
   localparam int unsigned H_W     = 12;
   localparam int unsigned V_W     = 11;
   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned BAR_W   = H_ACTIVE / 8;
   localparam int unsigned BAR_CW  = (BAR_W > 1) ? $clog2(BAR_W) : 1;

   localparam logic [H_W-1:0]    H_LAST     = H_W'(H_TOTAL - 1);
   localparam logic [H_W-1:0]    H_ACT      = H_W'(H_ACTIVE);
   localparam logic [H_W-1:0]    H_ACT_LAST = H_W'(H_ACTIVE - 1);
   localparam logic [H_W-1:0]    HS_FIRST   = H_W'(H_ACTIVE + H_FP);
   localparam logic [H_W-1:0]    HS_LAST    = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [V_W-1:0]    V_LAST     = V_W'(V_TOTAL - 1);
   localparam logic [V_W-1:0]    V_ACT      = V_W'(V_ACTIVE);
   localparam logic [V_W-1:0]    V_ACT_LAST = V_W'(V_ACTIVE - 1);
   localparam logic [V_W-1:0]    VS_FIRST   = V_W'(V_ACTIVE + V_FP);
   localparam logic [V_W-1:0]    VS_LAST    = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [BAR_CW-1:0] BAR_LAST   = BAR_CW'(BAR_W - 1);

   logic [H_W-1:0]    h_cnt_q, h_cnt_d;
   logic [V_W-1:0]    v_cnt_q, v_cnt_d;
   logic [7:0]        frame_cnt_q, frame_cnt_d;
   logic [1:0]        mode_q, mode_d;
   logic              run_q, run_d;
   logic [BAR_CW-1:0] bar_px_q, bar_px_d;
   logic [2:0]        bar_idx_q, bar_idx_d;
   logic              de_q, de_d;
   logic              hs_q, hs_d;
   logic              vs_q, vs_d;
   logic              fs_q, fs_d;
   logic [23:0]       rgb_q, rgb_d;

   logic              at_origin;
   logic              active;
   logic [1:0]        mode_eff;
   logic [23:0]       bar_rgb;
   logic              grid_on;

   // Counters, mode latch and region/pattern decode
   always_comb begin
      h_cnt_d     = h_cnt_q;
      v_cnt_d     = v_cnt_q;
      frame_cnt_d = frame_cnt_q;
      mode_d      = mode_q;
      run_d       = 1'b1;
      bar_px_d    = bar_px_q;
      bar_idx_d   = bar_idx_q;
      de_d        = 1'b0;
      hs_d        = ~HS_POL;
      vs_d        = ~VS_POL;
      fs_d        = 1'b0;
      rgb_d       = 24'h000000;

      at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);
      active    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
      // The first pixel of a frame already uses the freshly sampled mode.
      mode_eff  = at_origin ? I_mode : mode_q;
      grid_on   = (h_cnt_q[4:0] == 5'd0) || (v_cnt_q[4:0] == 5'd0) ||
                  (h_cnt_q == H_ACT_LAST) || (v_cnt_q == V_ACT_LAST);

      case (bar_idx_q)
         3'd0:    bar_rgb = 24'hFFFFFF;
         3'd1:    bar_rgb = 24'hFFFF00;
         3'd2:    bar_rgb = 24'h00FFFF;
         3'd3:    bar_rgb = 24'h00FF00;
         3'd4:    bar_rgb = 24'hFF00FF;
         3'd5:    bar_rgb = 24'hFF0000;
         3'd6:    bar_rgb = 24'h0000FF;
         default: bar_rgb = 24'h000000;
      endcase

      if (at_origin) begin
         mode_d = I_mode;
      end

      // After reset the counters hold at (0,0) for one cycle before running.
      if (run_q) begin
         if (h_cnt_q == H_LAST) begin
            h_cnt_d   = '0;
            bar_px_d  = '0;
            bar_idx_d = '0;
            if (v_cnt_q == V_LAST) begin
               v_cnt_d     = '0;
               frame_cnt_d = frame_cnt_q + 8'd1;
            end else begin
               v_cnt_d = v_cnt_q + V_W'(1);
            end
         end else begin
            h_cnt_d = h_cnt_q + H_W'(1);
            if (h_cnt_q < H_ACT) begin
               if (bar_px_q == BAR_LAST) begin
                  bar_px_d  = '0;
                  bar_idx_d = bar_idx_q + 3'd1;
               end else begin
                  bar_px_d = bar_px_q + BAR_CW'(1);
               end
            end
         end

         de_d = active;
         hs_d = ((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST)) ? HS_POL : ~HS_POL;
         vs_d = ((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST)) ? VS_POL : ~VS_POL;
         fs_d = at_origin;

         if (active) begin
            case (mode_eff)
               2'd0:    rgb_d = bar_rgb;
               2'd1:    rgb_d = grid_on ? 24'hFFFFFF : 24'h000000;
               2'd2:    rgb_d = {h_cnt_q[7:0], v_cnt_q[7:0], frame_cnt_q};
               default: rgb_d = 24'h808080;
            endcase
         end
      end
   end

   always_ff @(posedge I_rgb_clk) begin
      if (I_rst) begin
         h_cnt_q     <= '0;
         v_cnt_q     <= '0;
         frame_cnt_q <= 8'd0;
         mode_q      <= 2'd0;
         run_q       <= 1'b0;
         bar_px_q    <= '0;
         bar_idx_q   <= 3'd0;
         de_q        <= 1'b0;
         hs_q        <= ~HS_POL;
         vs_q        <= ~VS_POL;
         fs_q        <= 1'b0;
         rgb_q       <= 24'h000000;
      end else begin
         h_cnt_q     <= h_cnt_d;
         v_cnt_q     <= v_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         mode_q      <= mode_d;
         run_q       <= run_d;
         bar_px_q    <= bar_px_d;
         bar_idx_q   <= bar_idx_d;
         de_q        <= de_d;
         hs_q        <= hs_d;
         vs_q        <= vs_d;
         fs_q        <= fs_d;
         rgb_q       <= rgb_d;
      end
   end

   assign O_rgb_vs      = vs_q;
   assign O_rgb_hs      = hs_q;
   assign O_rgb_de      = de_q;
   assign O_rgb_r       = rgb_q[23:16];
   assign O_rgb_g       = rgb_q[15:8];
   assign O_rgb_b       = rgb_q[7:0];
   assign O_frame_start = fs_q;

endmodule

// File: tb/tb_rgb_timing_pattern_gen.sv
// Directed bench for rgb_timing_pattern_gen using small timing (24 x 8 total, 16 x 4 active).
// t counts clock edges since I_rst fell; pixel (x,y) of frame k is on the outputs at t = 2 + 192*k + 24*y + x.
module tb_rgb_timing_pattern_gen;
   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] mode;
   logic       vs, hs, de, fs;
   logic [7:0] r, g, b;

   int checks = 0;
   int errors = 0;
   int t      = 0;

   typedef struct {
      int         t;
      logic [1:0] mode;
      logic       de;
      logic       hs;
      logic       vs;
      logic       fs;
      logic [23:0] rgb;
   } vec_t;

   vec_t vecs[24];

   rgb_timing_pattern_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4),  .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1)
   ) dut (
      .I_rgb_clk    (clk),
      .I_rst        (rst),
      .I_mode       (mode),
      .O_rgb_vs     (vs),
      .O_rgb_hs     (hs),
      .O_rgb_de     (de),
      .O_rgb_r      (r),
      .O_rgb_g      (g),
      .O_rgb_b      (b),
      .O_frame_start(fs)
   );

   initial forever #5 clk = ~clk;

   // Advance n rising edges, then settle on the following falling edge.
   task automatic step(input int n);
      if (n > 0) begin
         for (int i = 0; i < n; i++) @(posedge clk);
         @(negedge clk);
         t += n;
      end
   endtask

   task automatic step_to(input int target);
      step(target - t);
   endtask

   task automatic do_reset(input logic [1:0] m);
      rst  = 1'b1;
      mode = m;
      step(3);
      rst = 1'b0;
      t   = 0;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0d actual=%h required=%h", name, t, act, exp);
      end
   endtask

   function automatic logic [31:0] outs();
      return 32'({de, hs, vs, fs, r, g, b});
   endfunction

   function automatic logic [31:0] pix();
      return 32'({de, r, g, b});
   endfunction

   int de_n, hs_n, vs_n, blank_bad, guard;
   logic [23:0] wrap_exp[3];

   initial begin
      // t, mode, de, hs, vs, fs, rgb
      vecs[0]  = '{1,   2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
      vecs[1]  = '{2,   2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 24'hFFFFFF};
      vecs[2]  = '{3,   2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 24'hFFFFFF};
      vecs[3]  = '{4,   2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 24'hFFFF00};
      vecs[4]  = '{6,   2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h00FFFF};
      vecs[5]  = '{8,   2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h00FF00};
      vecs[6]  = '{10,  2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 24'hFF00FF};
      vecs[7]  = '{12,  2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 24'hFF0000};
      vecs[8]  = '{14,  2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0000FF};
      vecs[9]  = '{16,  2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000};
      vecs[10] = '{17,  2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000};
      vecs[11] = '{18,  2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
      vecs[12] = '{19,  2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
      vecs[13] = '{20,  2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000};
      vecs[14] = '{22,  2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000};
      vecs[15] = '{23,  2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
      vecs[16] = '{26,  2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 24'hFFFFFF};
      vecs[17] = '{98,  2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
      vecs[18] = '{121, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
      vecs[19] = '{122, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000};
      vecs[20] = '{140, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000};
      vecs[21] = '{169, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000};
      vecs[22] = '{170, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
      vecs[23] = '{194, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 24'hFFFFFF};
      wrap_exp[0] = 24'h0302FF;
      wrap_exp[1] = 24'h030200;
      wrap_exp[2] = 24'h030201;

      rst  = 1'b1;
      mode = 2'd0;
      @(negedge clk);

      // Reset state
      do_reset(2'd0);
      chk("reset_outputs", outs(), 32'h0);

      // Bars and timing table after release
      foreach (vecs[i]) begin
         mode = vecs[i].mode;
         step_to(vecs[i].t);
         chk($sformatf("vec%0d", i), outs(),
             32'({vecs[i].de, vecs[i].hs, vecs[i].vs, vecs[i].fs, vecs[i].rgb}));
      end

      // Per-frame counts and blanking in every mode
      for (int m = 0; m < 4; m++) begin
         do_reset(2'(m));
         step(1);
         de_n = 0; hs_n = 0; vs_n = 0; blank_bad = 0;
         for (int c = 0; c < 192; c++) begin
            step(1);
            if (de) de_n++;
            if (hs) hs_n++;
            if (vs) vs_n++;
            if (!de && ({r, g, b} != 24'h0)) blank_bad++;
            if (m == 3 && t == 29) chk("grey_pixel", pix(), 32'h1808080);
         end
         chk($sformatf("de_count_m%0d", m), 32'(de_n), 32'd64);
         chk($sformatf("hs_count_m%0d", m), 32'(hs_n), 32'd24);
         chk($sformatf("vs_count_m%0d", m), 32'(vs_n), 32'd48);
         chk($sformatf("blank_rgb_m%0d", m), 32'(blank_bad), 32'd0);
         if (m == 0) begin
            for (int k = 0; k < 2; k++) begin
               guard = 0;
               do begin
                  step(1);
                  guard++;
               end while (!fs && guard < 400);
               chk($sformatf("frame_start_%0d", k + 1), 32'(t), 32'(2 + 192 * (k + 1)));
            end
         end
      end

      // Grid pattern
      do_reset(2'd1);
      step_to(9);  chk("grid_7_0",  pix(), 32'h1FFFFFF);
      step_to(41); chk("grid_15_1", pix(), 32'h1FFFFFF);
      step_to(50); chk("grid_0_2",  pix(), 32'h1FFFFFF);
      step_to(55); chk("grid_5_2",  pix(), 32'h1000000);
      step_to(79); chk("grid_5_3",  pix(), 32'h1FFFFFF);
      step_to(89); chk("grid_15_3", pix(), 32'h1FFFFFF);

      // Reset asserted mid-line with the counters at (7,2)
      do_reset(2'd0);
      step_to(56); chk("pre_reset_pixel", pix(), 32'h100FF00);
      rst = 1'b1;
      step(1); chk("midline_reset_now", outs(), 32'h0);
      step(2); chk("midline_reset_hold", outs(), 32'h0);
      rst = 1'b0;
      t   = 0;
      step(1); chk("restart_hold", outs(), 32'h0);
      step(1); chk("restart_origin", outs(), 32'h9FFFFFF);

      // Mode change mid-frame, then frame counter wrap in gradient mode
      do_reset(2'd0);
      step_to(31);
      mode = 2'd2;
      step_to(52);  chk("frame0_still_bars", pix(), 32'h1FFFF00);
      step_to(194); chk("frame1_origin", {fs, pix()}, {1'b1, 32'h1000001});
      step_to(245); chk("frame1_px_3_2", pix(), 32'h1030201);
      for (int k = 0; k < 3; k++) begin
         step_to(53 + 192 * (255 + k));
         chk($sformatf("frame%0d_px_3_2", 255 + k), pix(), 32'({1'b1, wrap_exp[k]}));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
